ctrl_seq: RTL and testbench

Microcode-free control sequencer for the 16-bit SAP core. It steps fetch/execute T-states and decodes the instruction register opcode. It drives every datapath load/enable strobe, including flag_write to the 2-bit flag register. It uses that register's output (carry, zero) to resolve conditional jumps.

---
 rtl/ctrl_seq_if.sv | 35 +++
 rtl/ctrl_seq.sv | 146 ++++++++++++++
 tb/tb_ctrl_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_if.sv
// Control bundle between the SAP sequencer and the datapath.
// The master side is the sequencer: it reads status and drives every strobe.
interface ctrl_seq_if #(
  parameter int OPCODE_W = 4
);
  logic                run;
  logic [OPCODE_W-1:0] ir_opcode;
  logic [1:0]          flag_out;
  logic                mem_ready;

  logic pc_out, pc_inc, pc_load;
  logic mar_in;
  logic mem_rd, mem_wr;
  logic ir_in, ir_out;
  logic a_in, a_out, b_in;
  logic alu_out, alu_sub;
  logic flag_write;
  logic out_in;
  logic halted;
  logic [2:0] t_state;

  modport master (
    input  run, ir_opcode, flag_out, mem_ready,
    output pc_out, pc_inc, pc_load, mar_in, mem_rd, mem_wr, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flag_write, out_in,
           halted, t_state
  );

  modport slave (
    output run, ir_opcode, flag_out, mem_ready,
    input  pc_out, pc_inc, pc_load, mar_in, mem_rd, mem_wr, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, alu_sub, flag_write, out_in,
           halted, t_state
  );
endinterface

// File: rtl/ctrl_seq.sv
// Hardwired fetch/execute sequencer for the 16-bit SAP core.
// Only the T-state is registered; every strobe is decoded combinationally.
module ctrl_seq #(
  parameter int OPCODE_W = 4,
  parameter bit WAIT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_seq_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F0   = 3'd1;
  localparam logic [2:0] S_F1   = 3'd2;
  localparam logic [2:0] S_E0   = 3'd3;
  localparam logic [2:0] S_E1   = 3'd4;
  localparam logic [2:0] S_E2   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  logic [2:0] state, state_nxt;
  logic       rdy;
  logic pc_out, pc_inc, pc_load, mar_in, mem_rd, mem_wr, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, alu_sub, flag_write, out_in;

  assign rdy = WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_in     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_in      = 1'b0;
    ir_out     = 1'b0;
    a_in       = 1'b0;
    a_out      = 1'b0;
    b_in       = 1'b0;
    alu_out    = 1'b0;
    alu_sub    = 1'b0;
    flag_write = 1'b0;
    out_in     = 1'b0;
    case (state)
      S_IDLE: if (bus.run) state_nxt = S_F0;
      S_F0: begin
        pc_out    = 1'b1;
        mar_in    = 1'b1;
        state_nxt = S_F1;
      end
      S_F1: begin
        mem_rd = 1'b1;
        if (rdy) begin
          ir_in     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_E0;
        end
      end
      S_E0: begin
        state_nxt = S_F0;
        case (bus.ir_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_out    = 1'b1;
            mar_in    = 1'b1;
            state_nxt = S_E1;
          end
          OP_LDI: begin ir_out = 1'b1; a_in = 1'b1; end
          OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; end
          OP_JC:  begin ir_out = 1'b1; pc_load = bus.flag_out[1]; end
          OP_JZ:  begin ir_out = 1'b1; pc_load = bus.flag_out[0]; end
          OP_OUT: begin a_out = 1'b1; out_in = 1'b1; end
          OP_HLT: state_nxt = S_HALT;
          default: ;
        endcase
      end
      // Memory steps hold their strobes until ready; the load only fires on the ready cycle.
      S_E1: begin
        state_nxt = S_F0;
        case (bus.ir_opcode)
          OP_LDA: begin
            mem_rd = 1'b1;
            a_in   = rdy;
            if (!rdy) state_nxt = S_E1;
          end
          OP_ADD, OP_SUB: begin
            mem_rd    = 1'b1;
            b_in      = rdy;
            state_nxt = rdy ? S_E2 : S_E1;
          end
          OP_STA: begin
            a_out  = 1'b1;
            mem_wr = 1'b1;
            if (!rdy) state_nxt = S_E1;
          end
          default: ;
        endcase
      end
      S_E2: begin
        state_nxt = S_F0;
        if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
          alu_out    = 1'b1;
          a_in       = 1'b1;
          flag_write = 1'b1;
          alu_sub    = (bus.ir_opcode == OP_SUB);
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pc_out     = pc_out;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_load    = pc_load;
  assign bus.mar_in     = mar_in;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.ir_in      = ir_in;
  assign bus.ir_out     = ir_out;
  assign bus.a_in       = a_in;
  assign bus.a_out      = a_out;
  assign bus.b_in       = b_in;
  assign bus.alu_out    = alu_out;
  assign bus.alu_sub    = alu_sub;
  assign bus.flag_write = flag_write;
  assign bus.out_in     = out_in;
  assign bus.halted     = (state == S_HALT);
  assign bus.t_state    = state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq against a per-instruction step table.
// A second instance with WAIT_EN=0 checks that mem_ready is ignored there.
module tb_ctrl_seq;

  localparam logic [15:0] PC_OUT  = 16'h0001, PC_INC  = 16'h0002, PC_LOAD = 16'h0004;
  localparam logic [15:0] MAR_IN  = 16'h0008, MEM_RD  = 16'h0010, MEM_WR  = 16'h0020;
  localparam logic [15:0] IR_IN   = 16'h0040, IR_OUT  = 16'h0080, A_IN    = 16'h0100;
  localparam logic [15:0] A_OUT   = 16'h0200, B_IN    = 16'h0400, ALU_OUT = 16'h0800;
  localparam logic [15:0] ALU_SUB = 16'h1000, FLAG_WR = 16'h2000, OUT_IN  = 16'h4000;
  localparam logic [15:0] HALTED  = 16'h8000;
  localparam logic [15:0] DRIVERS = PC_OUT | IR_OUT | A_OUT | ALU_OUT | MEM_RD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ctrl_seq_if #(.OPCODE_W(4)) bus ();
  ctrl_seq_if #(.OPCODE_W(4)) bus0 ();

  ctrl_seq #(.OPCODE_W(4), .WAIT_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ctrl_seq #(.OPCODE_W(4), .WAIT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int npass = 0;
  int ntot  = 0;

  // Step table for the instruction under test: fixed strobes, strobes gated by ready, stall flag
  logic [15:0] st_fix  [8];
  logic [15:0] st_gate [8];
  bit          st_wait [8];
  int          n_steps;
  bit          st_halt;

  function automatic logic [15:0] vec();
    return {bus.halted, bus.out_in, bus.flag_write, bus.alu_sub, bus.alu_out, bus.b_in,
            bus.a_out, bus.a_in, bus.ir_out, bus.ir_in, bus.mem_wr, bus.mem_rd,
            bus.mar_in, bus.pc_load, bus.pc_inc, bus.pc_out};
  endfunction

  function automatic logic [15:0] vec0();
    return {bus0.halted, bus0.out_in, bus0.flag_write, bus0.alu_sub, bus0.alu_out, bus0.b_in,
            bus0.a_out, bus0.a_in, bus0.ir_out, bus0.ir_in, bus0.mem_wr, bus0.mem_rd,
            bus0.mar_in, bus0.pc_load, bus0.pc_inc, bus0.pc_out};
  endfunction

  // Cycles from F0 to the next F0 with no stalls
  function automatic int latency(input int op);
    case (op)
      1, 4:    return 4;
      2, 3:    return 5;
      default: return 3;
    endcase
  endfunction

  task automatic build_steps(input int op, input logic [1:0] fl);
    for (int i = 0; i < 8; i++) begin
      st_fix[i] = '0; st_gate[i] = '0; st_wait[i] = 1'b0;
    end
    st_fix[0] = PC_OUT | MAR_IN;
    st_fix[1] = MEM_RD; st_gate[1] = IR_IN | PC_INC; st_wait[1] = 1'b1;
    n_steps = 3;
    st_halt = 1'b0;
    case (op)
      1: begin
        st_fix[2] = IR_OUT | MAR_IN;
        st_fix[3] = MEM_RD; st_gate[3] = A_IN; st_wait[3] = 1'b1;
        n_steps = 4;
      end
      2, 3: begin
        st_fix[2] = IR_OUT | MAR_IN;
        st_fix[3] = MEM_RD; st_gate[3] = B_IN; st_wait[3] = 1'b1;
        st_fix[4] = ALU_OUT | A_IN | FLAG_WR | ((op == 3) ? ALU_SUB : 16'h0);
        n_steps = 5;
      end
      4: begin
        st_fix[2] = IR_OUT | MAR_IN;
        st_fix[3] = A_OUT | MEM_WR; st_wait[3] = 1'b1;
        n_steps = 4;
      end
      5:  st_fix[2] = IR_OUT | A_IN;
      6:  st_fix[2] = IR_OUT | PC_LOAD;
      7:  st_fix[2] = IR_OUT | (fl[1] ? PC_LOAD : 16'h0);
      8:  st_fix[2] = IR_OUT | (fl[0] ? PC_LOAD : 16'h0);
      14: st_fix[2] = A_OUT | OUT_IN;
      15: st_halt = 1'b1;
      default: ;
    endcase
  endtask

  // Entered at posedge+1 with the DUT in F0; leaves at posedge+1 in the following state.
  task automatic exec_instr(input int op, input logic [1:0] fl, input int f1w, input int exw);
    int step, cyc, nw, stl, tgt;
    logic rdy;
    logic [15:0] exp, got;
    bus.ir_opcode = 4'(op);
    bus.flag_out  = fl;
    build_steps(op, fl);
    step = 0; cyc = 0; nw = 0; stl = 0;
    while (step < n_steps && cyc < 16) begin
      if (st_wait[step]) begin
        tgt = (step == 1) ? f1w : exw;
        rdy = (stl < tgt) ? 1'b0 : 1'b1;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.mem_ready = rdy;
      #1;
      exp = st_fix[step] | (rdy ? st_gate[step] : 16'h0);
      got = vec();
      ntot++;
      if (got !== exp) $display("FAIL strobes op=%0d step=%0d got=%h exp=%h", op, step, got, exp);
      else npass++;
      ntot++;
      if (bus.t_state !== 3'(step + 1))
        $display("FAIL t_state op=%0d step=%0d got=%0d exp=%0d", op, step, bus.t_state, step + 1);
      else npass++;
      ntot++;
      if ($countones(got & DRIVERS) > 1)
        $display("FAIL bus_drivers op=%0d step=%0d got=%h exp=at most one", op, step, got & DRIVERS);
      else npass++;
      cyc++;
      if (!st_wait[step] || rdy) begin step++; stl = 0; end
      else begin stl++; nw++; end
      @(posedge clk); #1;
    end
    ntot++;
    if (cyc != latency(op) + nw)
      $display("FAIL latency op=%0d got=%0d exp=%0d", op, cyc, latency(op) + nw);
    else npass++;
    ntot++;
    if (bus.t_state !== (st_halt ? 3'd7 : 3'd1))
      $display("FAIL next_state op=%0d got=%0d exp=%0d", op, bus.t_state, st_halt ? 7 : 1);
    else npass++;
  endtask

  // Pulse reset, request run; leaves at posedge+1 in F0.
  task automatic start_run();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
  endtask

  task automatic test_reset();
    start_run();
    bus.ir_opcode = 4'd2;
    bus.flag_out  = 2'b00;
    bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    #1;
    ntot++;
    if (bus.t_state !== 3'd4 || vec() !== MEM_RD)
      $display("FAIL add_e1 got t=%0d s=%h exp t=4 s=%h", bus.t_state, vec(), MEM_RD);
    else npass++;
    rst = 1'b0;
    #1;
    ntot++;
    if (bus.t_state !== 3'd0 || vec() !== 16'h0)
      $display("FAIL async_reset got t=%0d s=%h exp t=0 s=0", bus.t_state, vec());
    else npass++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ntot++;
      if (bus.t_state !== 3'd0 || vec() !== 16'h0)
        $display("FAIL idle_hold cyc=%0d got t=%0d s=%h exp t=0 s=0", i, bus.t_state, vec());
      else npass++;
    end
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    ntot++;
    if (bus.t_state !== 3'd1 || vec() !== (PC_OUT | MAR_IN))
      $display("FAIL run_to_f0 got t=%0d s=%h exp t=1 s=%h", bus.t_state, vec(), PC_OUT | MAR_IN);
    else npass++;
  endtask

  task automatic test_add_wait();
    exec_instr(2, 2'b00, 0, 2);
  endtask

  task automatic test_sub_jz();
    exec_instr(3, 2'b00, 0, 0);
    exec_instr(8, 2'b01, 0, 0);
    exec_instr(3, 2'b00, 1, 1);
    exec_instr(8, 2'b10, 0, 0);
  endtask

  task automatic test_jc();
    exec_instr(7, 2'b10, 0, 0);
    exec_instr(7, 2'b00, 0, 0);
    exec_instr(7, 2'b11, 1, 0);
    exec_instr(7, 2'b01, 0, 0);
  endtask

  task automatic test_mem_seq();
    exec_instr(4, 2'b00, 0, 2);
    exec_instr(1, 2'b00, 1, 1);
    exec_instr(5, 2'b00, 0, 0);
    exec_instr(14, 2'b11, 0, 0);
    exec_instr(6, 2'b00, 0, 0);
    exec_instr(0, 2'b00, 0, 0);
  endtask

  task automatic test_undefined();
    for (int op = 9; op <= 13; op++) exec_instr(op, 2'($urandom), 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      exec_instr(int'($urandom_range(0, 14)), 2'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
  endtask

  task automatic test_nowait();
    logic [15:0] exp0 [5];
    exp0[0] = PC_OUT | MAR_IN;
    exp0[1] = MEM_RD | IR_IN | PC_INC;
    exp0[2] = IR_OUT | MAR_IN;
    exp0[3] = MEM_RD | A_IN;
    exp0[4] = PC_OUT | MAR_IN;
    bus0.ir_opcode = 4'd1;
    bus0.flag_out  = 2'b00;
    bus0.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus0.run = 1'b1;
    @(posedge clk); #1;
    bus0.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ntot++;
      if (bus0.t_state !== ((i == 4) ? 3'd1 : 3'(i + 1)) || vec0() !== exp0[i])
        $display("FAIL nowait cyc=%0d got t=%0d s=%h exp s=%h", i, bus0.t_state, vec0(), exp0[i]);
      else npass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    start_run();
    exec_instr(15, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bus.run       = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      ntot++;
      if (bus.t_state !== 3'd7 || vec() !== HALTED)
        $display("FAIL halt_hold cyc=%0d got t=%0d s=%h exp t=7 s=%h", i, bus.t_state, vec(), HALTED);
      else npass++;
      @(posedge clk); #1;
    end
    bus.run = 1'b0;
    rst = 1'b0;
    #1;
    ntot++;
    if (bus.t_state !== 3'd0 || bus.halted !== 1'b0)
      $display("FAIL halt_reset got t=%0d halted=%b exp t=0 halted=0", bus.t_state, bus.halted);
    else npass++;
    rst = 1'b1;
  endtask

  initial begin
    bus.run = 1'b0; bus.ir_opcode = '0; bus.flag_out = '0; bus.mem_ready = 1'b0;
    bus0.run = 1'b0; bus0.ir_opcode = '0; bus0.flag_out = '0; bus0.mem_ready = 1'b0;
    #12;
    ntot++;
    if (bus.t_state !== 3'd0 || vec() !== 16'h0)
      $display("FAIL reset_state got t=%0d s=%h exp t=0 s=0", bus.t_state, vec());
    else npass++;
    test_reset();
    test_add_wait();
    test_sub_jz();
    test_jc();
    test_mem_seq();
    test_undefined();
    test_random();
    test_nowait();
    test_halt();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
